cobs_frame_packetizer: RTL and testbench
========================================

// Module: cobs_frame_packetizer
// PURPOSE
// - Gathers one sample from each of NUM_CHANNELS AXI-Stream sample channels (XADC
//   voltage/current and future channels) into one frame. Frame = seq byte + samples.
// - COBS-encodes the frame and emits it byte-wise with a 0x00 delimiter on an 8-bit
//   AXI-Stream toward the ft232h USB FIFO sys_axis sink.
// - Sits between xadc_drp_axis_adapter channel outputs and the ft232h sys_axis input.
// PARAMETERS
// - NUM_CHANNELS  2   sample channels per frame, 1..64 (raw frame <= 253 bytes incl. CRC)
// - SAMPLE_WIDTH  12  valid LSBs per sample, 1..16; upper bits zero-extended to 16
// PORTS
// - clk            in   1                          system clock
// - rst            in   1                          synchronous, active-high reset
// - s_axis_tdata   in   NUM_CHANNELS*SAMPLE_WIDTH  ch k at [k*SAMPLE_WIDTH +: SAMPLE_WIDTH]
// - s_axis_tvalid  in   NUM_CHANNELS               per-channel valid
// - s_axis_tready  out  NUM_CHANNELS               per-channel ready
// - m_axis_tdata   out  8                          encoded byte
// - m_axis_tvalid  out  1                          byte valid
// - m_axis_tready  in   1                          sink ready
// - m_axis_tlast   out  1                          high on 0x00 delimiter byte only
// BEHAVIOUR
// - Reset: s_axis_tready=0, m_axis_tvalid=0, m_axis_tlast=0, m_axis_tdata=0, seq=0,
//   FSM=COLLECT. Reset mid-frame discards the partial frame; no byte after the reset edge.
// - COLLECT: s_axis_tready = {N{&s_axis_tvalid}}. All channels are captured in the same
//   cycle only. Partial valids are never consumed. Capture -> SCAN next cycle.
// - Raw frame, byte order: seq, then per channel k=0..N-1 sample LSB, MSB. Optional CRC
//   byte last. L = 1 + 2*N (+1 with CRC).
// - seq increments by 1 per captured frame and wraps 255 -> 0.
// - SCAN: walk the buffer from the group start to the next 0x00 or end of frame. Compute
//   code = run length + 1. Run length 0..253. Scan rate 1 byte/cycle.
// - EMIT_CODE: present code. EMIT_DATA: present the run's non-zero bytes. If the group
//   ended on a zero, skip that zero and start a new group: SCAN, then EMIT_CODE.
// - Trailing zero or zero-length group emits code 0x01.
// - EMIT_DELIM: present 0x00 with tlast=1. On handshake -> COLLECT.
// - Output handshake: a byte transfers when m_axis_tvalid & m_axis_tready.
//   While tvalid=1 and tready=0, tdata/tlast hold stable.
//   tvalid never drops before its handshake, except on rst.
// - The encoded stream never contains 0x00 except the delimiter.
// - Throughput: with tready held high, the frame completes within 2*(L+2)+2 cycles of
//   capture. No new capture until the delimiter handshakes.
// - m_axis_tvalid is low in COLLECT and SCAN.
// CONFIGURATION
// - PACKETIZER_CRC8_EN defined: append CRC-8 to the raw frame before encoding.
//   Poly 0x07, init 0x00, no reflection, no xorout, computed over seq and sample bytes.
// - PACKETIZER_CRC8_EN undefined: no CRC byte and no CRC logic; L = 1 + 2*N.
// TESTING
// - N=2, W=12, no CRC, first frame ch0=0x123, ch1=0x0AB.
//   Raw 00 23 01 AB 00 -> out 01 04 23 01 AB 01 00, tlast on the final 00 only.
// - ch0=0xFFF, ch1=0x001, seq=0x05: raw 05 FF 0F 01 00 -> out 05 05 FF 0F 01 01 00.
// - Stall: drop tready for 3 cycles mid-frame. tdata/tvalid stay stable. Byte sequence
//   is identical to the unstalled run; no byte is duplicated or lost.
// - Only ch0 valid for 10 cycles, then ch1 valid: s_axis_tready stays 0 until both are
//   valid, then pulses 1 for exactly one cycle. One frame is produced.
// - 257 back-to-back frames: seq runs 00..FF, 00. A seq of 00 always encodes as leading
//   code 01.
// - rst asserted during EMIT_DATA: tvalid=0 on the next cycle. The next frame has seq=00.
//   With CRC8_EN, frame 1 is raw 00 23 01 AB 00 + CRC over 00 23 01 AB.

Source files
------------

// File: rtl/cobs_frame_packetizer.sv
// cobs_frame_packetizer: gathers one sample per channel into a seq-numbered frame, COBS-encodes it and streams bytes ending in a 0x00 delimiter.
// Define PACKETIZER_CRC8_EN to append a CRC-8 (poly 0x07) byte to the raw frame before encoding.
module cobs_frame_packetizer #(
  parameter int NUM_CHANNELS = 2,
  parameter int SAMPLE_WIDTH = 12
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [NUM_CHANNELS*SAMPLE_WIDTH-1:0] s_axis_tdata,
  input  logic [NUM_CHANNELS-1:0]              s_axis_tvalid,
  output logic [NUM_CHANNELS-1:0]              s_axis_tready,
  output logic [7:0]                           m_axis_tdata,
  output logic                                 m_axis_tvalid,
  input  logic                                 m_axis_tready,
  output logic                                 m_axis_tlast
);
  localparam int L_RAW = 1 + 2*NUM_CHANNELS;
`ifdef PACKETIZER_CRC8_EN
  localparam int L = L_RAW + 1;
`else
  localparam int L = L_RAW;
`endif
  localparam int AW = $clog2(L + 1);
  localparam int FW = (1 << AW) * 8;
  localparam logic [AW-1:0] LEN = AW'(L);
  typedef enum logic [2:0] {COLLECT, SCAN, EMIT_CODE, EMIT_DATA, EMIT_DELIM} state_t;
  state_t r_state, w_next;
  logic [7:0] r_seq;
  logic [FW-1:0] r_buf, w_frame;
  logic [L_RAW*8-1:0] w_raw;
  logic [AW-1:0] r_ptr, r_rd;
  logic [7:0] w_byte, w_data, w_code;
  logic w_cap, w_hs, w_more, w_run0, w_last_data;
  assign w_raw[7:0] = r_seq;
  for (genvar k = 0; k < NUM_CHANNELS; k++) begin : g_ch
    assign w_raw[16*k+8 +: 16] = 16'(s_axis_tdata[k*SAMPLE_WIDTH +: SAMPLE_WIDTH]);
  end
`ifdef PACKETIZER_CRC8_EN
  logic [7:0] w_crc;
  function automatic logic [7:0] crc8_step(input logic [7:0] c, input logic [7:0] b);
    logic [7:0] r;
    r = c ^ b;
    for (int i = 0; i < 8; i++) r = r[7] ? ({r[6:0], 1'b0} ^ 8'h07) : {r[6:0], 1'b0};
    return r;
  endfunction
  always_comb begin
    w_crc = '0;
    for (int i = 0; i < L_RAW; i++) w_crc = crc8_step(w_crc, w_raw[i*8 +: 8]);
  end
  assign w_frame = FW'({w_crc, w_raw});
`else
  assign w_frame = FW'(w_raw);
`endif
  // Buffer slots past the frame read as zero, so the scan also stops at end of frame.
  assign w_byte = r_buf[{r_ptr, 3'b000} +: 8];
  assign w_data = r_buf[{r_rd, 3'b000} +: 8];
  assign w_code = 8'(r_ptr) - 8'(r_rd) + 8'd1;
  assign w_cap = !rst && (r_state == COLLECT) && (&s_axis_tvalid);
  assign s_axis_tready = {NUM_CHANNELS{w_cap}};
  assign w_hs = m_axis_tvalid && m_axis_tready;
  assign w_more = r_ptr != LEN;
  assign w_run0 = r_ptr == r_rd;
  assign w_last_data = (r_rd + AW'(1)) == r_ptr;
  always_comb begin
    w_next = r_state;
    m_axis_tvalid = 1'b0;
    m_axis_tlast = 1'b0;
    m_axis_tdata = '0;
    case (r_state)
      COLLECT: w_next = w_cap ? SCAN : COLLECT;
      SCAN: w_next = (w_byte == 8'h00) ? EMIT_CODE : SCAN;
      EMIT_CODE: begin
        m_axis_tvalid = 1'b1;
        m_axis_tdata = w_code;
        if (m_axis_tready) w_next = !w_run0 ? EMIT_DATA : w_more ? SCAN : EMIT_DELIM;
      end
      EMIT_DATA: begin
        m_axis_tvalid = 1'b1;
        m_axis_tdata = w_data;
        if (m_axis_tready && w_last_data) w_next = w_more ? SCAN : EMIT_DELIM;
      end
      EMIT_DELIM: begin
        m_axis_tvalid = 1'b1;
        m_axis_tlast = 1'b1;
        if (m_axis_tready) w_next = COLLECT;
      end
      default: w_next = COLLECT;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= COLLECT;
      r_seq <= '0;
      r_ptr <= '0;
      r_rd <= '0;
    end else begin
      r_state <= w_next;
      if (w_cap) begin
        r_buf <= w_frame;
        r_seq <= r_seq + 8'd1;
        r_ptr <= '0;
        r_rd <= '0;
      end
      if (r_state == SCAN && w_byte != 8'h00) r_ptr <= r_ptr + AW'(1);
      if (r_state == EMIT_DATA && w_hs) r_rd <= r_rd + AW'(1);
      // Group ended on a zero: skip it and start the next group right after.
      if ((r_state == EMIT_CODE || r_state == EMIT_DATA) && w_next == SCAN) begin
        r_ptr <= r_ptr + AW'(1);
        r_rd <= r_ptr + AW'(1);
      end
    end
  end
endmodule

// File: tb/tb_cobs_frame_packetizer.sv
// tb_cobs_frame_packetizer: scoreboard bench; stimulus queues expected encoded bytes, a monitor pops and compares on every output handshake.
module tb_cobs_frame_packetizer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [23:0] s_tdata = '0;
  logic [1:0] s_tvalid = '0;
  logic [1:0] s_tready;
  logic [7:0] m_tdata;
  logic m_tvalid, m_tlast;
  logic m_tready = 1'b1;
  typedef struct packed {logic [7:0] d; logic l;} exp_t;
  exp_t q[$];
  int checks = 0, fails = 0, delims = 0, frames = 0;
  logic [7:0] exp_seq = '0;
  logic [7:0] v_ex1 [7] = '{8'h01, 8'h04, 8'h23, 8'h01, 8'hAB, 8'h01, 8'h00};
  logic [7:0] v_ex2 [7] = '{8'h05, 8'h05, 8'hFF, 8'h0F, 8'h01, 8'h01, 8'h00};
  logic [7:0] v_none [7] = '{default: 8'h00};
  logic prev_stall = 1'b0;
  logic [7:0] prev_d = '0;
  logic prev_l = 1'b0;

  cobs_frame_packetizer #(.NUM_CHANNELS(2), .SAMPLE_WIDTH(12)) dut (
    .clk(clk), .rst(rst),
    .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid), .s_axis_tready(s_tready),
    .m_axis_tdata(m_tdata), .m_axis_tvalid(m_tvalid), .m_axis_tready(m_tready),
    .m_axis_tlast(m_tlast)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] crc8(input logic [7:0] c, input logic [7:0] b);
    logic [7:0] r;
    r = c ^ b;
    for (int i = 0; i < 8; i++) r = r[7] ? ((r << 1) ^ 8'h07) : (r << 1);
    return r;
  endfunction

  // Reference COBS encoder with back-patched code bytes.
  task automatic push_model(input logic [11:0] c0, input logic [11:0] c1);
    logic [7:0] raw[$];
    logic [7:0] o[$];
    logic [7:0] code, crc;
    int ci;
    raw = '{exp_seq, c0[7:0], {4'h0, c0[11:8]}, c1[7:0], {4'h0, c1[11:8]}};
    crc = '0;
    foreach (raw[i]) crc = crc8(crc, raw[i]);
`ifdef PACKETIZER_CRC8_EN
    raw.push_back(crc);
`endif
    ci = 0;
    o.push_back(8'h00);
    code = 8'd1;
    foreach (raw[i]) begin
      if (raw[i] == 8'h00) begin
        o[ci] = code;
        ci = o.size();
        o.push_back(8'h00);
        code = 8'd1;
      end else begin
        o.push_back(raw[i]);
        code = code + 8'd1;
      end
    end
    o[ci] = code;
    foreach (o[i]) q.push_back('{o[i], 1'b0});
    q.push_back('{8'h00, 1'b1});
  endtask

  task automatic send(input logic [11:0] c0, input logic [11:0] c1, input bit hand, input logic [7:0] h [7]);
    int n;
    bit use_hand;
    use_hand = hand;
`ifdef PACKETIZER_CRC8_EN
    use_hand = 1'b0;
`endif
    @(posedge clk); #1;
    s_tdata = {c1, c0};
    s_tvalid = 2'b11;
    n = 0;
    do begin @(negedge clk); n++; end while (s_tready != 2'b11 && n < 400);
    if (s_tready != 2'b11) begin
      checks++; fails++;
      $display("FAIL capture_timeout: tready=%b required 11", s_tready);
    end else begin
      if (use_hand) for (int i = 0; i < 7; i++) q.push_back('{h[i], i == 6});
      else push_model(c0, c1);
      exp_seq = exp_seq + 8'd1;
      frames++;
    end
    @(posedge clk); #1;
    s_tvalid = 2'b00;
  endtask

  task automatic drain(input int budget, input string name);
    int n;
    n = 0;
    while (q.size() != 0 && n < budget) begin @(negedge clk); #1; n++; end
    checks++;
    if (q.size() != 0) begin
      fails++;
      $display("FAIL %s: %0d bytes still pending after %0d cycles, required 0", name, q.size(), n);
    end
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    if (rst) prev_stall <= 1'b0;
    else begin
      if (prev_stall) begin
        checks++;
        if (!m_tvalid || m_tdata !== prev_d || m_tlast !== prev_l) begin
          fails++;
          $display("FAIL stall_hold: valid=%b data=%02h last=%b required 1/%02h/%b", m_tvalid, m_tdata, m_tlast, prev_d, prev_l);
        end
      end
      if (m_tvalid && m_tready) begin
        checks++;
        if (q.size() == 0) begin
          fails++;
          $display("FAIL unexpected_byte: got %02h last=%b, none expected", m_tdata, m_tlast);
        end else begin
          e = q.pop_front();
          if (m_tdata !== e.d || m_tlast !== e.l) begin
            fails++;
            $display("FAIL out_byte: got %02h last=%b required %02h last=%b", m_tdata, m_tlast, e.d, e.l);
          end
        end
        if (m_tlast) delims++;
      end
      prev_stall <= m_tvalid && !m_tready;
      prev_d <= m_tdata;
      prev_l <= m_tlast;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    s_tvalid = 2'b11;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (s_tready !== 2'b00 || m_tvalid !== 1'b0 || m_tlast !== 1'b0 || m_tdata !== 8'h00) begin
      fails++;
      $display("FAIL reset_state: tready=%b tvalid=%b tlast=%b tdata=%02h required 00/0/0/00", s_tready, m_tvalid, m_tlast, m_tdata);
    end
    @(posedge clk); #1;
    s_tvalid = 2'b00;
    rst = 1'b0;
    send(12'h123, 12'h0AB, 1'b1, v_ex1);
    drain(2*(5+2)+2, "throughput_ex1");
    for (int i = 0; i < 4; i++) begin
      send(12'(i*300 + 7), 12'(i == 2 ? 0 : 12'h800 + i), 1'b0, v_none);
      drain(2*(5+2)+2, "throughput_model");
    end
    send(12'hFFF, 12'h001, 1'b1, v_ex2);
    drain(2*(5+2)+2, "throughput_ex2");
    send(12'h1FF, 12'h2EE, 1'b0, v_none);
    repeat (7) @(posedge clk);
    #1 m_tready = 1'b0;
    repeat (3) @(posedge clk);
    #1 m_tready = 1'b1;
    drain(40, "stall_drain");
    @(posedge clk); #1;
    s_tdata = {12'h456, 12'h789};
    s_tvalid = 2'b01;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checks++;
      if (s_tready !== 2'b00) begin
        fails++;
        $display("FAIL partial_valid: tready=%b required 00", s_tready);
      end
    end
    @(posedge clk); #1;
    s_tvalid = 2'b11;
    @(negedge clk);
    checks++;
    if (s_tready !== 2'b11) begin
      fails++;
      $display("FAIL all_valid: tready=%b required 11", s_tready);
    end else begin
      push_model(12'h789, 12'h456);
      exp_seq = exp_seq + 8'd1;
      frames++;
    end
    @(posedge clk); @(negedge clk);
    checks++;
    if (s_tready !== 2'b00) begin
      fails++;
      $display("FAIL ready_pulse: tready=%b required 00", s_tready);
    end
    @(posedge clk); #1;
    s_tvalid = 2'b00;
    drain(40, "partial_drain");
    send(12'h123, 12'h0AB, 1'b0, v_none);
    n = 0;
    do begin @(negedge clk); n++; end while (!(m_tvalid && m_tdata == 8'h23) && n < 100);
    @(posedge clk); #1;
    rst = 1'b1;
    q.delete();
    frames--;
    @(posedge clk); @(negedge clk);
    checks++;
    if (m_tvalid !== 1'b0) begin
      fails++;
      $display("FAIL reset_mid_frame: tvalid=%b required 0", m_tvalid);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    exp_seq = '0;
    for (int i = 0; i < 257; i++)
      send(12'(i*37), (i % 5 == 0) ? 12'h000 : 12'(i*91 + 5), 1'b0, v_none);
    drain(200, "sweep_drain");
    repeat (3) @(negedge clk);
    checks++;
    if (delims != frames) begin
      fails++;
      $display("FAIL frame_count: delimiters=%0d required %0d", delims, frames);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
